// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared fetch-sequencer types and defaults
package pc_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          PC_INC       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_redirect_sel.sv
// rtl/pc_redirect_sel.sv - trap > jmp > br redirect priority mux (PC_ALIGN_CHECK_EN adds misalign flag)
module pc_redirect_sel #(
    parameter int XLEN = 32
) (
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            redir,
    output logic [XLEN-1:0] redir_tgt,
    output logic            misalign
);

    logic            any_redir;
    logic [XLEN-1:0] sel_tgt;

    // Pick the single highest-priority redirect source for this cycle.
    always_comb begin
        any_redir = trap_valid | jmp_valid | br_taken;
        if (trap_valid) begin
            sel_tgt = trap_vector;
        end else if (jmp_valid) begin
            sel_tgt = jmp_target;
        end else begin
            sel_tgt = br_target;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // A misaligned target is dropped; only the fault flag escapes.
    assign redir     = any_redir && (sel_tgt[1:0] == 2'b00);
    assign misalign  = any_redir && (sel_tgt[1:0] != 2'b00);
    assign redir_tgt = sel_tgt;
`else
    // Without the check, low bits are simply cleared so the PC stays word aligned.
    assign redir     = any_redir;
    assign misalign  = 1'b0;
    assign redir_tgt = sel_tgt & {{(XLEN-2){1'b1}}, 2'b00};
`endif

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - kill-aware fetch PC sequencer, one fetch outstanding (option: PC_ALIGN_CHECK_EN)
module pc_sequencer #(
    parameter int                     XLEN         = pc_pkg::XLEN,
    parameter logic [pc_pkg::XLEN-1:0] RESET_VECTOR = pc_pkg::RESET_VECTOR,
    parameter int                     PC_INC       = pc_pkg::PC_INC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            if_req,
    output logic [XLEN-1:0] if_addr,
    input  logic            if_gnt,
    input  logic            if_rvalid,
    input  logic [31:0]     if_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst_word,
    output logic            misalign_fault
);

    import pc_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            pend_valid;
    logic [XLEN-1:0] pend_tgt;

    logic            redir;
    logic [XLEN-1:0] redir_tgt;
    logic            sel_misalign;
    logic [XLEN-1:0] next_tgt;

    pc_redirect_sel #(.XLEN(XLEN)) u_redirect_sel (
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .trap_valid  (trap_valid),
        .trap_vector (trap_vector),
        .redir       (redir),
        .redir_tgt   (redir_tgt),
        .misalign    (sel_misalign)
    );

    // A redirect arriving this cycle is newer than anything already pending.
    assign next_tgt = redir ? redir_tgt : pend_tgt;

    // The address is only presented in REQ; stall merely holds the request back.
    assign if_req  = (state == REQ) && !stall;
    assign if_addr = pc;

    // Fetch FSM: owns the PC, records redirects and kills stale responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_VECTOR;
            pend_valid     <= 1'b0;
            pend_tgt       <= RESET_VECTOR;
            inst_valid     <= 1'b0;
            inst_pc        <= RESET_VECTOR;
            inst_word      <= 32'h0;
            misalign_fault <= 1'b0;
        end else begin
            inst_valid     <= 1'b0;
            misalign_fault <= sel_misalign;
            if (redir) begin
                pend_valid <= 1'b1;
                pend_tgt   <= redir_tgt;
            end
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (if_req && if_gnt) begin
                        state <= WAIT;
                    end else if (redir || pend_valid) begin
                        pc         <= next_tgt;
                        pend_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (if_rvalid) begin
                        if (redir || pend_valid) begin
                            pc         <= next_tgt;
                            pend_valid <= 1'b0;
                        end else begin
                            inst_valid <= 1'b1;
                            inst_pc    <= pc;
                            inst_word  <= if_rdata;
                            pc         <= pc + XLEN'(PC_INC);
                        end
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (PC_ALIGN_CHECK_EN selects misalign expectations)
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        br_taken, jmp_valid, trap_valid;
    logic [31:0] br_target, jmp_target, trap_vector;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        inst_valid, misalign_fault;
    logic [31:0] inst_pc, inst_word;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jmp_valid      (jmp_valid),
        .jmp_target     (jmp_target),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rvalid      (if_rvalid),
        .if_rdata       (if_rdata),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_word      (inst_word),
        .misalign_fault (misalign_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } inst_t;

    inst_t       exp_q[$];
    logic [31:0] gnt_q[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cycle = 0;
    int          lat   = 2;
    int          mem_cnt = 0;
    int          prev_iv = -1;
    bit          gnt_en, force_rv, mem_pending, spacing_en, last_gnt;
    logic [31:0] mem_addr, last_gaddr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic inst_t mk(input logic [31:0] a);
        inst_t t;
        t.pc   = a;
        t.word = word_of(a);
        return t;
    endfunction

    // One clock: memory model drives gnt/rvalid, then grants and deliveries are scored.
    task automatic tick();
        bit          granted, served;
        logic [31:0] gaddr;
        inst_t       e;
        #1;
        if_gnt    = gnt_en;
        served    = mem_pending && (mem_cnt == 0);
        if_rvalid = force_rv || served;
        if_rdata  = word_of(mem_addr);
        #1;
        granted = if_req && if_gnt && !rst;
        gaddr   = if_addr;
        @(posedge clk);
        #1;
        cycle++;
        if (rst || served) mem_pending = 1'b0;
        else if (mem_pending) mem_cnt--;
        last_gnt   = granted;
        last_gaddr = gaddr;
        if (granted) begin
            mem_pending = 1'b1;
            mem_cnt     = lat - 1;
            mem_addr    = gaddr;
            if (gnt_q.size() == 0) check("gnt_unexpected", {31'b0, granted}, 32'h0);
            else check("gnt_addr", gaddr, gnt_q.pop_front());
        end
        if (inst_valid) begin
            if (exp_q.size() == 0) begin
                check("inst_unexpected", {31'b0, inst_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_word", inst_word, e.word);
            end
            if (spacing_en && prev_iv >= 0) check("iv_spacing", 32'(cycle - prev_iv), 32'd3);
            prev_iv = cycle;
        end
        br_taken   = 1'b0;
        jmp_valid  = 1'b0;
        trap_valid = 1'b0;
        force_rv   = 1'b0;
    endtask

    task automatic wait_grant(input logic [31:0] a);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(last_gnt && last_gaddr == a) && n < 40);
        if (!(last_gnt && last_gaddr == a)) check("gnt_timeout", last_gaddr, a);
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!if_req && n < 20);
        if (!if_req) check("req_timeout", {31'b0, if_req}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0;
        br_taken = 1'b0; jmp_valid = 1'b0; trap_valid = 1'b0;
        br_target = 32'h0; jmp_target = 32'h0; trap_vector = 32'h0;
        if_gnt = 1'b0; if_rvalid = 1'b0; if_rdata = 32'h0;
        gnt_en = 1'b1; force_rv = 1'b0; mem_pending = 1'b0; mem_addr = 32'h0;
        spacing_en = 1'b0; last_gnt = 1'b0; last_gaddr = 32'h0;

        repeat (3) tick();
        check("rst_if_req", {31'b0, if_req}, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_word", inst_word, 32'h0);
        check("rst_misalign", {31'b0, misalign_fault}, 32'h0);

        // Sequential fetch, memory latency 2: one delivery every 3 cycles.
        rst = 1'b0;
        gnt_q.push_back(32'h0); gnt_q.push_back(32'h4); gnt_q.push_back(32'h8);
        exp_q.push_back(mk(32'h0)); exp_q.push_back(mk(32'h4));
        spacing_en = 1'b1;
        wait_grant(32'h8);
        spacing_en = 1'b0;

        // Branch while 0x8 is outstanding: its response must be killed.
        br_taken = 1'b1; br_target = 32'h100;
        gnt_q.push_back(32'h100); exp_q.push_back(mk(32'h100));
        wait_grant(32'h100);
        gnt_en = 1'b0;
        wait_req();

        // Simultaneous redirects in REQ: trap wins and applies next cycle.
        trap_valid = 1'b1; trap_vector = 32'h200;
        jmp_valid = 1'b1;  jmp_target = 32'h300;
        br_taken = 1'b1;   br_target = 32'h400;
        tick();
        check("prio_addr", if_addr, 32'h200);
        check("prio_req", {31'b0, if_req}, 32'h1);
        gnt_q.push_back(32'h200); exp_q.push_back(mk(32'h200));
        gnt_en = 1'b1;
        wait_grant(32'h200);
        gnt_en = 1'b0;
        wait_req();

        // Stall holds the request low while memory keeps offering grants.
        stall = 1'b1; gnt_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req", {31'b0, if_req}, 32'h0);
            check("stall_addr", if_addr, 32'h204);
        end
        stall = 1'b0;
        gnt_q.push_back(32'h204); exp_q.push_back(mk(32'h204));
        wait_grant(32'h204);
        gnt_en = 1'b0;
        wait_req();

        // Wrap-around of the sequential increment.
        jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
        tick();
        check("wrap_redir_addr", if_addr, 32'hFFFF_FFFC);
        gnt_q.push_back(32'hFFFF_FFFC); gnt_q.push_back(32'h0);
        exp_q.push_back(mk(32'hFFFF_FFFC));
        gnt_en = 1'b1;
        wait_grant(32'h0);
        gnt_en = 1'b0;

        // Reset while the fetch of 0x0 is outstanding.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_if_req", {31'b0, if_req}, 32'h0);
        check("rstw_if_addr", if_addr, 32'h0);
        check("rstw_inst_pc", inst_pc, 32'h0);
        check("rstw_inst_valid", {31'b0, inst_valid}, 32'h0);
        force_rv = 1'b1;
        tick();
        check("stray_rvalid", {31'b0, inst_valid}, 32'h0);
        wait_req();

        // Misaligned jump target.
        jmp_valid = 1'b1; jmp_target = 32'h102;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_flag", {31'b0, misalign_fault}, 32'h1);
        check("misalign_addr", if_addr, 32'h0);
        tick();
        check("misalign_pulse", {31'b0, misalign_fault}, 32'h0);
        check("misalign_hold", if_addr, 32'h0);
`else
        check("misalign_flag", {31'b0, misalign_fault}, 32'h0);
        check("misalign_addr", if_addr, 32'h100);
`endif

        check("exp_drained", 32'(exp_q.size()), 32'h0);
        check("gnt_drained", 32'(gnt_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
